mac4_engine: RTL and testbench
==============================

// Module: mac4_engine
// PURPOSE
//  Four-lane unsigned multiply-accumulate stage directly upstream of the write-back stage.
//  Each accepted input sample is multiplied by four per-lane coefficients and accumulated.
//  After TERMS samples, the four sums are presented on MU1..MU4 with a one-cycle web strobe.
//  A cooldown guarantees write-back has drained before the next strobe.
// PARAMETERS
//  DATA_W   8   input sample width (unsigned)
//  COEF_W   7   coefficient width (unsigned)
//  ACC_W    18  accumulator / result width
//  TERMS    4   samples accumulated per result group
//  GROUPS   4   result groups per job
//  COOLDOWN 4   min cycles from a web pulse to the next web pulse (>=4, the write-back burst)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        synchronous reset, active-high
//  start      in   1        job start pulse; honoured only in IDLE
//  in_valid   in   1        sample valid
//  in_ready   out  1        sample accepted when in_valid & in_ready
//  in_data    in   DATA_W   sample, broadcast to all lanes
//  coef1..4   in   COEF_W   per-lane coefficient, sampled with the accepted sample
//  web        out  1        one-cycle strobe: MU1..MU4 valid, write-back starts
//  MU1..MU4   out  ACC_W    lane results, held stable until the next web
//  busy       out  1        high from accepted start until done
//  done       out  1        one-cycle pulse after the last group's web
// BEHAVIOUR
//  Reset (sync, 1 cycle): state=IDLE; acc, MU1..4, counters = 0; web, done, busy, in_ready = 0.
//  States:
//   IDLE  : in_ready=0. start -> ACCUM; clears accumulators, term_cnt and grp_cnt.
//   ACCUM : in_ready=1. Each beat: acc_k <= sat(acc_k + in_data*coef_k), term_cnt++.
//           When beat TERMS is accepted -> EMIT.
//   EMIT  : one cycle. MU_k <= acc_k, acc_k <= 0, term_cnt <= 0, web=1, grp_cnt++.
//           -> COOL.
//   COOL  : in_ready=0. Wait until COOLDOWN cycles have elapsed since web.
//           Then: grp_cnt==GROUPS -> IDLE with done=1; otherwise -> ACCUM.
//  Timing:
//   web is registered: it is high in the cycle the new MU values first appear.
//   Last-beat accept to web = 1 cycle.
//  Arithmetic:
//   Product is DATA_W+COEF_W bits, zero-extended to ACC_W.
//   Sum saturates at 2^ACC_W-1 and never wraps. Defaults cannot saturate
//   (max 4*255*127 = 129540).
//  Holding requirements:
//   MU1 is read by write-back in the cycle after web; MU2..4 are latched at web.
//   All MU outputs therefore hold until the next EMIT.
//  Boundary cases:
//   - in_valid while in_ready=0: ignored, no state change.
//   - start while busy: ignored.
//   - start and in_valid in the same IDLE cycle: only start is taken.
//   - rst mid-ACCUM or mid-COOL: full return to reset values next cycle; a pending web is
//     suppressed.
//   - grp_cnt and term_cnt are sized to TERMS and GROUPS and never wrap within a job.
//  busy = (state != IDLE).
// STRUCTURE
//  Shared package: state encoding (IDLE/ACCUM/EMIT/COOL); ACC_W, DATA_W, COEF_W constants,
//  also used by write-back.
//  One sub-module: mac_lane (multiply, zero-extend, saturating accumulate, clear).
//  Instantiated 4x.
//  The FSM and counters live in mac4_engine.
// TESTING
//  1 Reset: rst high 2 cycles mid-ACCUM -> all outputs 0, state IDLE, no web.
//  2 Single group: TERMS=4, coef=1,2,3,4, samples 1,2,3,4 back-to-back
//    -> web 1 cycle after 4th accept; MU1..4 = 10,20,30,40.
//  3 Job of 4 groups, in_valid always high -> exactly 4 web pulses, >=COOLDOWN cycles apart;
//    done once after the last; busy falls with done.
//  4 Throttled in_valid (every 3rd cycle), samples 255, all coef 127
//    -> MU1..4 = 129540, no saturation flag.
//  5 Saturation build with TERMS=16, ACC_W=18, max inputs -> MU = 262143 and held.
//  6 Stability: MU1..4 unchanged for all cycles between web pulses.
//    start during busy ignored (group count unaffected).

Source files
------------

// File: rtl/mac4_engine_pkg.sv
// Shared constants and FSM encoding for the four-lane MAC stage; write-back imports the widths too.
package mac4_engine_pkg;

  localparam int MAC_DATA_W = 8;
  localparam int MAC_COEF_W = 7;
  localparam int MAC_ACC_W  = 18;
  localparam int MAC_LANES  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_EMIT,
    S_COOL
  } state_t;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mac4_engine_if.sv
// Sample stream into the MAC stage: one broadcast sample plus four per-lane coefficients.
interface mac4_engine_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 7
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [COEF_W-1:0] coef1;
  logic [COEF_W-1:0] coef2;
  logic [COEF_W-1:0] coef3;
  logic [COEF_W-1:0] coef4;

  modport master (
    output in_valid, in_data, coef1, coef2, coef3, coef4,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, coef1, coef2, coef3, coef4,
    output in_ready
  );
endinterface

// File: rtl/mac4_engine_mac_lane.sv
// One MAC lane: unsigned multiply, zero-extend, saturating accumulate with synchronous clear.
module mac_lane
  import mac4_engine_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W,
  parameter int COEF_W = MAC_COEF_W,
  parameter int ACC_W  = MAC_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  input  logic [COEF_W-1:0] coef,
  output logic [ACC_W-1:0]  acc_next
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_W{1'b1}});

  logic [ACC_W-1:0]  acc;
  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  sum;

  assign prod     = PROD_W'(data) * PROD_W'(coef);
  assign sum      = SUM_W'(acc) + SUM_W'(prod);
  assign acc_next = (sum > ACC_MAX) ? '1 : sum[ACC_W-1:0];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/mac4_engine.sv
// Four-lane MAC engine: accumulates TERMS samples per group, strobes web with MU1..MU4,
// then cools down before the next group; GROUPS groups make one job.
module mac4_engine
  import mac4_engine_pkg::*;
#(
  parameter int DATA_W   = MAC_DATA_W,
  parameter int COEF_W   = MAC_COEF_W,
  parameter int ACC_W    = MAC_ACC_W,
  parameter int TERMS    = 4,
  parameter int GROUPS   = 4,
  parameter int COOLDOWN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  mac4_engine_if.slave     sample,
  output logic             web,
  output logic [ACC_W-1:0] MU1,
  output logic [ACC_W-1:0] MU2,
  output logic [ACC_W-1:0] MU3,
  output logic [ACC_W-1:0] MU4,
  output logic             busy,
  output logic             done
);
  localparam int TC_W = cnt_w(TERMS);
  localparam int GC_W = cnt_w(GROUPS);
  localparam int CC_W = cnt_w(COOLDOWN);

  state_t state, state_next;
  logic [TC_W-1:0] term_cnt, term_next;
  logic [GC_W-1:0] grp_cnt, grp_next;
  logic [CC_W-1:0] cool_cnt, cool_next;
  logic            web_next, done_next;
  logic            accept, last_beat, lane_clear;

  logic [COEF_W-1:0] coef     [MAC_LANES];
  logic [ACC_W-1:0]  acc_next [MAC_LANES];

  assign coef[0] = sample.coef1;
  assign coef[1] = sample.coef2;
  assign coef[2] = sample.coef3;
  assign coef[3] = sample.coef4;

  assign sample.in_ready = (state == S_ACCUM);
  assign busy            = (state != S_IDLE);
  assign accept          = sample.in_valid && sample.in_ready;
  assign last_beat       = accept && (term_cnt == TC_W'(TERMS - 1));
  assign lane_clear      = ((state == S_IDLE) && start) || (state == S_EMIT);

  for (genvar k = 0; k < MAC_LANES; k++) begin : g_lane
    mac_lane #(
      .DATA_W(DATA_W),
      .COEF_W(COEF_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clear   (lane_clear),
      .en      (accept),
      .data    (sample.in_data),
      .coef    (coef[k]),
      .acc_next(acc_next[k])
    );
  end

  always_comb begin
    state_next = state;
    term_next  = term_cnt;
    grp_next   = grp_cnt;
    cool_next  = cool_cnt;
    web_next   = 1'b0;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_ACCUM;
          term_next  = '0;
          grp_next   = '0;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          term_next = term_cnt + TC_W'(1);
          if (last_beat) begin
            state_next = S_EMIT;
            web_next   = 1'b1;
          end
        end
      end
      S_EMIT: begin
        term_next  = '0;
        grp_next   = grp_cnt + GC_W'(1);
        cool_next  = CC_W'(1);
        state_next = S_COOL;
      end
      S_COOL: begin
        if (cool_cnt >= CC_W'(COOLDOWN - 1)) begin
          if (grp_cnt == GC_W'(GROUPS)) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = S_ACCUM;
          end
        end else begin
          cool_next = cool_cnt + CC_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      term_cnt <= '0;
      grp_cnt  <= '0;
      cool_cnt <= '0;
      web      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      term_cnt <= term_next;
      grp_cnt  <= grp_next;
      cool_cnt <= cool_next;
      web      <= web_next;
      done     <= done_next;
    end
  end

  // MU loads from the lanes' next-sum on the last accepted beat, so the results
  // appear together with the registered web in the EMIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      MU1 <= '0;
      MU2 <= '0;
      MU3 <= '0;
      MU4 <= '0;
    end else if (last_beat) begin
      MU1 <= acc_next[0];
      MU2 <= acc_next[1];
      MU3 <= acc_next[2];
      MU4 <= acc_next[3];
    end
  end

endmodule

// File: tb/tb_mac4_engine.sv
// Bench for mac4_engine: default instance plus a TERMS=16 saturation instance, both
// checked every cycle against a job-level reference model.
module tb_mac4_engine;
  import mac4_engine_pkg::*;

  localparam int SAT      = 262143;
  localparam int COOLDOWN = 4;

  typedef struct packed {
    logic              active;
    logic              ready;
    logic              web;
    logic              done;
    logic [3:0][31:0]  mu;
    logic [3:0][31:0]  sum;
    logic [31:0]       terms;
    logic [31:0]       groups;
    logic [31:0]       wait_c;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  always #5 clk = ~clk;

  mac4_engine_if #(.DATA_W(8), .COEF_W(7)) bus_a ();
  mac4_engine_if #(.DATA_W(8), .COEF_W(7)) bus_b ();

  logic        web_a, busy_a, done_a, web_b, busy_b, done_b;
  logic [17:0] mu_a [4];
  logic [17:0] mu_b [4];

  mac4_engine #(.TERMS(4), .GROUPS(4), .COOLDOWN(4)) dut (
    .clk(clk), .rst(rst), .start(start_a), .sample(bus_a), .web(web_a),
    .MU1(mu_a[0]), .MU2(mu_a[1]), .MU3(mu_a[2]), .MU4(mu_a[3]),
    .busy(busy_a), .done(done_a)
  );

  mac4_engine #(.TERMS(16), .GROUPS(1), .COOLDOWN(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start_b), .sample(bus_b), .web(web_b),
    .MU1(mu_b[0]), .MU2(mu_b[1]), .MU3(mu_b[2]), .MU4(mu_b[3]),
    .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int web_cnt = 0;
  int done_cnt = 0;
  int last_web = -1;
  int min_gap = 1000;
  bit chk_en = 1'b0;
  bit acc_a = 1'b0;
  bit acc_b = 1'b0;
  model_t ma = '0;
  model_t mb = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a job is GROUPS groups of TERMS accepted samples; each group ends with
  // a web the cycle after its last accept, then input stays closed for COOLDOWN cycles.
  function automatic model_t step(input model_t m, input logic r, input logic st, input logic v,
                                  input logic [7:0] d, input logic [3:0][6:0] c,
                                  input int nt, input int ng);
    model_t n;
    longint s;
    if (r) return '0;
    n      = m;
    n.web  = 1'b0;
    n.done = 1'b0;
    if (!m.active) begin
      if (st) begin
        n.active = 1'b1;
        n.ready  = 1'b1;
        n.sum    = '0;
        n.terms  = 0;
        n.groups = 0;
      end
    end else if (m.ready) begin
      if (v) begin
        for (int k = 0; k < 4; k++) begin
          s = longint'(m.sum[k]) + longint'(d) * longint'(c[k]);
          n.sum[k] = (s > SAT) ? 32'(SAT) : 32'(s);
        end
        n.terms = m.terms + 1;
        if (n.terms == 32'(nt)) begin
          n.mu     = n.sum;
          n.sum    = '0;
          n.terms  = 0;
          n.groups = m.groups + 1;
          n.web    = 1'b1;
          n.ready  = 1'b0;
          n.wait_c = COOLDOWN;
        end
      end
    end else begin
      n.wait_c = m.wait_c - 1;
      if (n.wait_c == 0) begin
        if (m.groups == 32'(ng)) begin
          n.active = 1'b0;
          n.done   = 1'b1;
        end else begin
          n.ready = 1'b1;
        end
      end
    end
    return n;
  endfunction

  task automatic cmp(input string tag, input model_t m, input logic web, input logic busy,
                     input logic done, input logic rdy, input logic [17:0] u0,
                     input logic [17:0] u1, input logic [17:0] u2, input logic [17:0] u3);
    check({tag, "_web"}, web, m.web);
    check({tag, "_busy"}, busy, m.active);
    check({tag, "_done"}, done, m.done);
    check({tag, "_ready"}, rdy, m.ready);
    check({tag, "_mu1"}, u0, m.mu[0]);
    check({tag, "_mu2"}, u1, m.mu[1]);
    check({tag, "_mu3"}, u2, m.mu[2]);
    check({tag, "_mu4"}, u3, m.mu[3]);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      cmp("a", ma, web_a, busy_a, done_a, bus_a.in_ready, mu_a[0], mu_a[1], mu_a[2], mu_a[3]);
      cmp("b", mb, web_b, busy_b, done_b, bus_b.in_ready, mu_b[0], mu_b[1], mu_b[2], mu_b[3]);
      if (web_a) begin
        if (last_web >= 0 && (cyc - last_web) < min_gap) min_gap = cyc - last_web;
        last_web = cyc;
        web_cnt++;
      end
      if (done_a) done_cnt++;
    end
    acc_a = bus_a.in_valid && ma.ready && !rst;
    acc_b = bus_b.in_valid && mb.ready && !rst;
    ma = step(ma, rst, start_a, bus_a.in_valid, bus_a.in_data,
              {bus_a.coef4, bus_a.coef3, bus_a.coef2, bus_a.coef1}, 4, 4);
    mb = step(mb, rst, start_b, bus_b.in_valid, bus_b.in_data,
              {bus_b.coef4, bus_b.coef3, bus_b.coef2, bus_b.coef1}, 16, 1);
    if (rst) chk_en = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic v, input logic [7:0] d, input logic [27:0] c);
    if (which == 0) begin
      bus_a.in_valid = v;
      bus_a.in_data  = d;
      bus_a.coef1    = c[6:0];
      bus_a.coef2    = c[13:7];
      bus_a.coef3    = c[20:14];
      bus_a.coef4    = c[27:21];
    end else begin
      bus_b.in_valid = v;
      bus_b.in_data  = d;
      bus_b.coef1    = c[6:0];
      bus_b.coef2    = c[13:7];
      bus_b.coef3    = c[20:14];
      bus_b.coef4    = c[27:21];
    end
  endtask

  // Holds one sample until accepted; in_valid is offered only every period-th cycle.
  task automatic feed(input int which, input logic [7:0] d, input logic [27:0] c, input int period);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      drive(which, (period <= 1) || (cyc % period == 0), d, c);
      tick();
      got = (which == 0) ? acc_a : acc_b;
    end
    if (!got) begin
      errors++;
      $display("FAIL feed_timeout actual=no_accept required=accept (dut %0d)", which);
    end
  endtask

  task automatic pulse_start(input int which);
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int which);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      tick();
      seen = (which == 0) ? done_a : done_b;
    end
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout actual=0 required=1 (dut %0d)", which);
    end
  endtask

  function automatic logic [27:0] rand_coef();
    return 28'($urandom);
  endfunction

  initial begin
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", busy_a, 0);
    check("rst_ready", bus_a.in_ready, 0);
    check("rst_mu1", mu_a[0], 0);

    // Reset mid-ACCUM, asserted in the cycle the fourth beat is offered
    pulse_start(0);
    for (int i = 0; i < 3; i++) feed(0, 8'($urandom), rand_coef(), 1);
    drive(0, 1'b1, 8'd200, rand_coef());
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    drive(0, 1'b0, '0, '0);
    check("midrst_web", web_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_mu4", mu_a[3], 0);

    // Single group with known values, then the rest of the job with in_valid always high
    web_cnt = 0; done_cnt = 0; last_web = -1; min_gap = 1000;
    drive(0, 1'b1, 8'd9, {7'd4, 7'd3, 7'd2, 7'd1});
    pulse_start(0);
    for (int i = 1; i <= 4; i++) feed(0, 8'(i), {7'd4, 7'd3, 7'd2, 7'd1}, 1);
    check("grp1_web", web_a, 1);
    check("grp1_mu1", mu_a[0], 10);
    check("grp1_mu2", mu_a[1], 20);
    check("grp1_mu3", mu_a[2], 30);
    check("grp1_mu4", mu_a[3], 40);
    pulse_start(0);
    for (int i = 0; i < 12; i++) feed(0, 8'($urandom), rand_coef(), 1);
    drive(0, 1'b0, '0, '0);
    wait_done(0);
    check("job_busy_falls", busy_a, 0);
    repeat (2) tick();
    check("job_web_count", web_cnt, 4);
    check("job_done_count", done_cnt, 1);
    check("job_web_gap_ok", min_gap >= COOLDOWN, 1);

    // Throttled max-value inputs: largest unsaturated sum
    pulse_start(0);
    for (int i = 0; i < 16; i++) feed(0, 8'd255, {4{7'd127}}, 3);
    drive(0, 1'b0, '0, '0);
    wait_done(0);
    check("max_mu1", mu_a[0], 129540);
    check("max_mu2", mu_a[1], 129540);
    check("max_mu3", mu_a[2], 129540);
    check("max_mu4", mu_a[3], 129540);

    // Saturation on the TERMS=16 instance
    pulse_start(1);
    for (int i = 0; i < 16; i++) feed(1, 8'd255, {4{7'd127}}, 1);
    drive(1, 1'b0, '0, '0);
    wait_done(1);
    check("sat_mu1", mu_b[0], SAT);
    repeat (5) tick();
    check("sat_mu4_held", mu_b[3], SAT);

    // Random jobs with random throttle and stray start pulses
    for (int j = 0; j < 3; j++) begin
      pulse_start(0);
      for (int i = 0; i < 16; i++) begin
        feed(0, 8'($urandom), rand_coef(), int'($urandom_range(1, 3)));
        if ($urandom_range(0, 5) == 0) start_a = 1'b1;
      end
      drive(0, 1'b0, '0, '0);
      start_a = 1'b0;
      wait_done(0);
      tick();
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
